// File: rtl/router_stat_pkg.sv
// Shared types and constants for the mesh router statistics collector.
package router_stat_pkg;

  localparam int unsigned stat_num         = 4;
  localparam int unsigned stat_seq_width   = 8;
  localparam int unsigned stat_dir_width   = 4;
  localparam int unsigned stat_value_width = 32;

  localparam logic [1:0] tag_start_op  = 2'b10;
  localparam logic [1:0] tag_finish_op = 2'b11;

  typedef enum logic [1:0] {
    IDLE_STAT  = 2'd0,
    UTIL_STAT  = 2'd1,
    STALL_STAT = 2'd2,
    ARB_STAT   = 2'd3
  } router_stat_e;

  // Counter values narrower than stat_value_width are zero-extended.
  typedef struct packed {
    logic [stat_seq_width-1:0]   seq;
    logic [stat_dir_width-1:0]   dir;
    router_stat_e                stat;
    logic [stat_value_width-1:0] value;
  } router_stat_rec_s;

  // Lowest enabled statistic index in an emission mask.
  function automatic logic [1:0] first_stat(input logic [3:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/router_stat_dir_ctr.sv
// Event decode and four saturating statistic counters for one router output.
module router_stat_dir_ctr
  import router_stat_pkg::*;
#(
  parameter int unsigned inputs_p        = 5,
  parameter int unsigned ctr_width_p     = 32,
  parameter bit          clear_on_snap_p = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [inputs_p-1:0]                   req,
  input  logic [inputs_p-1:0]                   yumi,
  input  logic                                  enable,
  input  logic                                  snap,
  output logic [stat_num-1:0][ctr_width_p-1:0]  ctr
);

  logic any_req;
  logic grant;
  logic multi_req;
  logic [stat_num-1:0] inc;

  assign any_req   = |req;
  assign grant     = |(req & yumi);
  assign multi_req = |(req & (req - inputs_p'(1)));

  always_comb begin
    inc = '0;
    if (enable) begin
      inc[IDLE_STAT]  = !any_req;
      inc[UTIL_STAT]  = grant;
      inc[STALL_STAT] = any_req && !grant;
      inc[ARB_STAT]   = multi_req && grant;
    end
  end

  // In clear mode a snapshot restarts the window with this cycle's event.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ctr <= '0;
    end else begin
      for (int k = 0; k < stat_num; k++) begin
        if (snap && clear_on_snap_p) begin
          ctr[k] <= ctr_width_p'(inc[k]);
        end else if (inc[k] && (ctr[k] != '1)) begin
          ctr[k] <= ctr[k] + ctr_width_p'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mesh_router_stat_collector.sv
// Per-output router traffic statistics with tag-gated counting and a
// snapshot/drain engine streaming records over a valid/yumi interface.
module mesh_router_stat_collector
  import router_stat_pkg::*;
#(
  parameter int unsigned dims_p          = 2,
  parameter int unsigned ctr_width_p     = 32,
  parameter int unsigned period_p        = 250,
  parameter logic [3:0]  stat_mask_p     = 4'b1111,
  parameter bit          clear_on_snap_p = 1'b1,
  localparam int unsigned dirs_lp        = 1 + 2*dims_p
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [dirs_lp*dirs_lp-1:0]   req_i,
  input  logic [dirs_lp*dirs_lp-1:0]   yumi_i,
  input  logic                         tag_v_i,
  input  logic [31:0]                  tag_i,
  output logic                         out_v_o,
  output router_stat_rec_s             out_data_o,
  input  logic                         out_yumi_i,
  output logic                         overrun_o
);

  localparam int unsigned dir_width_lp    = $clog2(dirs_lp);
  localparam int unsigned period_width_lp = (period_p > 1) ? $clog2(period_p) : 1;
  localparam logic [1:0]  first_stat_lp   = first_stat(stat_mask_p);
  localparam logic [0:0]  st_idle         = 1'b0;
  localparam logic [0:0]  st_drain        = 1'b1;

  logic [stat_num-1:0][ctr_width_p-1:0] ctr      [dirs_lp];
  logic [stat_num-1:0][ctr_width_p-1:0] shadow_r [dirs_lp];

  logic [0:0]                 state_r, state_n;
  logic [dir_width_lp-1:0]    dir_r, dir_n;
  logic [1:0]                 stat_r, stat_n;
  router_stat_rec_s           rec_r, rec_n;
  logic [stat_seq_width-1:0]  seq_r;
  logic [period_width_lp-1:0] period_r;
  logic                       enable_r;
  logic                       overrun_r;
  logic                       out_v_r;

  logic start_tag, finish_tag, period_hit, trigger, snap;
  logic nxt_found;
  logic [1:0] nxt_stat;
  logic unused_tag;

  assign unused_tag = ^tag_i[29:0];
  assign start_tag  = tag_v_i && (tag_i[31:30] == tag_start_op);
  assign finish_tag = tag_v_i && (tag_i[31:30] == tag_finish_op);
  assign period_hit = (period_p != 0) && enable_r &&
                      (period_r == period_width_lp'(period_p - 1));
  assign trigger    = tag_v_i || period_hit;
  assign snap       = trigger && (state_r == st_idle);

  for (genvar o = 0; o < dirs_lp; o++) begin : g_dir
    router_stat_dir_ctr #(
      .inputs_p       (dirs_lp),
      .ctr_width_p    (ctr_width_p),
      .clear_on_snap_p(clear_on_snap_p)
    ) u_ctr (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .req      (req_i[o*dirs_lp +: dirs_lp]),
      .yumi     (yumi_i[o*dirs_lp +: dirs_lp]),
      .enable   (enable_r),
      .snap     (snap),
      .ctr      (ctr[o])
    );
  end

  // Enable, period counter, sequence number, shadow copy and overrun flag.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      enable_r  <= 1'b0;
      period_r  <= '0;
      seq_r     <= '0;
      overrun_r <= 1'b0;
      shadow_r  <= '{default: '0};
    end else begin
      if (start_tag)       enable_r <= 1'b1;
      else if (finish_tag) enable_r <= 1'b0;
      if (start_tag) begin
        period_r <= '0;
      end else if (enable_r && (period_p != 0)) begin
        period_r <= period_hit ? '0 : period_r + period_width_lp'(1);
      end
      if (snap) begin
        seq_r    <= seq_r + stat_seq_width'(1);
        shadow_r <= ctr;
      end
      if (trigger && (state_r == st_drain)) overrun_r <= 1'b1;
    end
  end

  // Drain FSM: next state, next walk position and next record.
  always_comb begin
    state_n   = state_r;
    dir_n     = dir_r;
    stat_n    = stat_r;
    rec_n     = rec_r;
    nxt_found = 1'b0;
    nxt_stat  = first_stat_lp;
    for (int k = 0; k < stat_num; k++) begin
      if (!nxt_found && (k > int'(stat_r)) && stat_mask_p[k]) begin
        nxt_stat  = 2'(k);
        nxt_found = 1'b1;
      end
    end
    case (state_r)
      st_idle: begin
        if (snap && (stat_mask_p != 4'b0000)) begin
          state_n     = st_drain;
          dir_n       = '0;
          stat_n      = first_stat_lp;
          rec_n.seq   = seq_r + stat_seq_width'(1);
          rec_n.dir   = '0;
          rec_n.stat  = router_stat_e'(first_stat_lp);
          rec_n.value = stat_value_width'(ctr[0][first_stat_lp]);
        end
      end
      st_drain: begin
        if (out_yumi_i) begin
          if (!nxt_found && (dir_r == dir_width_lp'(dirs_lp - 1))) begin
            state_n = st_idle;
          end else begin
            if (!nxt_found) dir_n = dir_r + dir_width_lp'(1);
            stat_n      = nxt_stat;
            rec_n.dir   = stat_dir_width'(dir_n);
            rec_n.stat  = router_stat_e'(stat_n);
            rec_n.value = stat_value_width'(shadow_r[dir_n][stat_n]);
          end
        end
      end
      default: state_n = st_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= st_idle;
      dir_r   <= '0;
      stat_r  <= '0;
      rec_r   <= '0;
      out_v_r <= 1'b0;
    end else begin
      state_r <= state_n;
      dir_r   <= dir_n;
      stat_r  <= stat_n;
      rec_r   <= rec_n;
      out_v_r <= (state_n == st_drain);
    end
  end

  assign out_v_o    = out_v_r;
  assign out_data_o = rec_r;
  assign overrun_o  = overrun_r;

endmodule

// File: tb/tb_mesh_router_stat_collector.sv
// Directed bench for mesh_router_stat_collector: a windowed full-mask instance
// and a periodic single-stat dims_p=3 instance.
module tb_mesh_router_stat_collector;
  import router_stat_pkg::*;

  localparam logic [31:0] tag_start  = 32'h8000_0000;
  localparam logic [31:0] tag_finish = 32'hC000_0000;
  localparam logic [31:0] tag_plain  = 32'h0000_1234;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [24:0]      a_req, a_yumi;
  logic             a_tag_v, a_oyumi, a_ov, a_overrun;
  logic [31:0]      a_tag;
  router_stat_rec_s a_data;

  logic [48:0]      b_req, b_yumi;
  logic             b_tag_v, b_oyumi, b_ov, b_overrun;
  logic [31:0]      b_tag;
  router_stat_rec_s b_data;

  int checks = 0;
  int errors = 0;
  int exp_a [5][4];

  mesh_router_stat_collector #(
    .dims_p(2), .ctr_width_p(5), .period_p(0),
    .stat_mask_p(4'b1111), .clear_on_snap_p(1'b1)
  ) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .req_i(a_req), .yumi_i(a_yumi),
    .tag_v_i(a_tag_v), .tag_i(a_tag), .out_v_o(a_ov), .out_data_o(a_data),
    .out_yumi_i(a_oyumi), .overrun_o(a_overrun)
  );

  mesh_router_stat_collector #(
    .dims_p(3), .ctr_width_p(8), .period_p(8),
    .stat_mask_p(4'b0010), .clear_on_snap_p(1'b1)
  ) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .req_i(b_req), .yumi_i(b_yumi),
    .tag_v_i(b_tag_v), .tag_i(b_tag), .out_v_o(b_ov), .out_data_o(b_data),
    .out_yumi_i(b_oyumi), .overrun_o(b_overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_a(input int idle_v);
    for (int d = 0; d < 5; d++) begin
      exp_a[d][0] = idle_v;
      for (int s = 1; s < 4; s++) exp_a[d][s] = 0;
    end
  endtask

  // Accepts all 20 records of instance A back to back, checking each.
  task automatic drain_a(input int exp_seq);
    for (int d = 0; d < 5; d++) begin
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("a_valid d%0d s%0d", d, s), 32'(a_ov), 32'd1);
        chk($sformatf("a_seq d%0d s%0d", d, s), 32'(a_data.seq), 32'(exp_seq));
        chk($sformatf("a_dir d%0d s%0d", d, s), 32'(a_data.dir), 32'(d));
        chk($sformatf("a_stat d%0d s%0d", d, s), 32'(a_data.stat), 32'(s));
        chk($sformatf("a_value d%0d s%0d", d, s), a_data.value, 32'(exp_a[d][s]));
        a_oyumi = 1'b1;
        step();
      end
    end
    a_oyumi = 1'b0;
    chk("a_valid_after_drain", 32'(a_ov), 32'd0);
    chk("a_overrun", 32'(a_overrun), 32'd0);
  endtask

  // Accepts the 7 utilized-only records of instance B; only N (dir 3) counts.
  task automatic drain_b(input int exp_seq, input int n_val);
    for (int d = 0; d < 7; d++) begin
      chk($sformatf("b_valid d%0d", d), 32'(b_ov), 32'd1);
      chk($sformatf("b_seq d%0d", d), 32'(b_data.seq), 32'(exp_seq));
      chk($sformatf("b_dir d%0d", d), 32'(b_data.dir), 32'(d));
      chk($sformatf("b_stat d%0d", d), 32'(b_data.stat), 32'd1);
      chk($sformatf("b_value d%0d", d), b_data.value, (d == 3) ? 32'(n_val) : 32'd0);
      b_oyumi = 1'b1;
      step();
    end
    b_oyumi = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = '0; a_yumi = '0; a_tag_v = 1'b0; a_tag = '0; a_oyumi = 1'b0;
    b_req = '0; b_yumi = '0; b_tag_v = 1'b0; b_tag = '0; b_oyumi = 1'b0;
    repeat (3) step();
    chk("reset_a_valid", 32'(a_ov), 32'd0);
    chk("reset_a_overrun", 32'(a_overrun), 32'd0);
    chk("reset_b_valid", 32'(b_ov), 32'd0);
    chk("reset_b_overrun", 32'(b_overrun), 32'd0);
    rst_n = 1'b1;
    step();

    // Traffic before any start tag is not counted and emits nothing.
    for (int i = 0; i < 100; i++) begin
      a_req  = 25'($urandom);
      a_yumi = a_req & 25'($urandom);
      step();
      chk("pre_start_valid", 32'(a_ov), 32'd0);
    end
    a_req = '0; a_yumi = '0;
    a_tag_v = 1'b1; a_tag = tag_finish;
    step();
    a_tag_v = 1'b0;
    fill_a(0);
    drain_a(1);

    // Start, then 20 idle cycles while draining, 10 arbitrated grants on E, 5 stalls.
    a_tag_v = 1'b1; a_tag = tag_start;
    step();
    a_tag_v = 1'b0;
    fill_a(0);
    drain_a(2);
    a_req = '0; a_req[10] = 1'b1; a_req[11] = 1'b1;
    a_yumi = '0; a_yumi[10] = 1'b1;
    repeat (10) step();
    a_yumi = '0; a_req[11] = 1'b0;
    repeat (5) step();
    a_req = '0;
    a_tag_v = 1'b1; a_tag = tag_finish;
    step();
    a_tag_v = 1'b0;
    fill_a(31);
    exp_a[2][0] = 20; exp_a[2][1] = 10; exp_a[2][2] = 5; exp_a[2][3] = 10;
    drain_a(3);

    // Finish-cycle idle event carries into the next window; then N saturates.
    a_tag_v = 1'b1; a_tag = tag_start;
    step();
    a_tag_v = 1'b0;
    fill_a(1);
    drain_a(4);
    a_req[15] = 1'b1; a_yumi[15] = 1'b1;
    repeat (40) step();
    a_req = '0; a_yumi = '0;
    a_tag_v = 1'b1; a_tag = tag_finish;
    step();
    a_tag_v = 1'b0;
    fill_a(31);
    exp_a[3][0] = 20; exp_a[3][1] = 31;
    drain_a(5);

    // Periodic windows on instance B with N granted every cycle.
    b_req[21] = 1'b1; b_yumi[21] = 1'b1;
    b_tag_v = 1'b1; b_tag = tag_start;
    step();
    b_tag_v = 1'b0;
    drain_b(1, 0);
    chk("b_gap1", 32'(b_ov), 32'd0);
    step();
    drain_b(2, 7);
    chk("b_gap2", 32'(b_ov), 32'd0);
    step();
    drain_b(3, 8);
    chk("b_gap3", 32'(b_ov), 32'd0);
    step();
    chk("b_snap4_valid", 32'(b_ov), 32'd1);
    chk("b_overrun_before", 32'(b_overrun), 32'd0);
    repeat (7) step();
    chk("b_overrun_edge_minus1", 32'(b_overrun), 32'd0);
    step();
    chk("b_overrun_set", 32'(b_overrun), 32'd1);
    chk("b_stall_dir", 32'(b_data.dir), 32'd0);
    chk("b_stall_valid", 32'(b_ov), 32'd1);
    drain_b(4, 8);
    chk("b_gap4", 32'(b_ov), 32'd0);
    step();
    drain_b(5, 16);
    chk("b_overrun_sticky", 32'(b_overrun), 32'd1);
    b_req = '0; b_yumi = '0;

    // Non-kernel tag snapshot, then reset in the middle of its drain.
    a_tag_v = 1'b1; a_tag = tag_plain;
    step();
    a_tag_v = 1'b0;
    chk("plain_valid", 32'(a_ov), 32'd1);
    chk("plain_seq", 32'(a_data.seq), 32'd6);
    chk("plain_value", a_data.value, 32'd1);
    a_oyumi = 1'b1;
    repeat (3) step();
    a_oyumi = 1'b0;
    chk("plain_fourth_stat", 32'(a_data.stat), 32'd3);
    rst_n = 1'b0;
    step();
    chk("midreset_a_valid", 32'(a_ov), 32'd0);
    chk("midreset_b_overrun", 32'(b_overrun), 32'd0);
    chk("midreset_b_valid", 32'(b_ov), 32'd0);
    rst_n = 1'b1;
    step();
    a_tag_v = 1'b1; a_tag = tag_finish;
    step();
    a_tag_v = 1'b0;
    fill_a(0);
    drain_a(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
